// File: rtl/axi4s_pkg.sv
// rtl/axi4s_pkg.sv - shared types and constants for the AXI4-Stream arbiter library
package axi4s_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotating-priority picker, search starts just above last
module rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Walk the ports from last+1 upward, wrapping at N; first requester wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      sum  = {1'b0, last} + (W+1)'(i);
      cand = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// rtl/axi4s_rr_arbiter.sv - packet-level round-robin merge of NUM_PORTS AXI4-Stream masters
module axi4s_rr_arbiter
  import axi4s_pkg::*;
#(
  parameter int AXI_WIDTH = 64,
  parameter int NUM_PORTS = 4,
  localparam int KEEP_W   = AXI_WIDTH / 8,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS*AXI_WIDTH-1:0] m_tdata_i,
  input  logic [NUM_PORTS*KEEP_W-1:0]    m_tkeep_i,
  input  logic [NUM_PORTS-1:0]           m_tlast_i,
  input  logic [NUM_PORTS-1:0]           m_tvalid_i,
  output logic [NUM_PORTS-1:0]           m_tready_o,
  output logic [AXI_WIDTH-1:0]           s_tdata_o,
  output logic [KEEP_W-1:0]              s_tkeep_o,
  output logic                           s_tlast_o,
  output logic                           s_tvalid_o,
  input  logic                           s_tready_i,
  output logic [IDX_W-1:0]               grant_idx_o,
  output logic                           busy_o,
  output logic [NUM_PORTS*PKT_CNT_W-1:0] pkt_count_o
);

  arb_state_t                     state_q, state_d;
  logic [IDX_W-1:0]               grant_q;
  logic [IDX_W-1:0]               last_q;
  logic [IDX_W-1:0]               pick_idx;
  logic                           pick_valid;
  logic                           beat_done;
  logic [NUM_PORTS*PKT_CNT_W-1:0] cnt_q;

  rr_picker #(
    .N(NUM_PORTS)
  ) u_picker (
    .req   (m_tvalid_i),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and datapath mux: only the granted port is visible while locked
  always_comb begin
    state_d    = state_q;
    s_tvalid_o = 1'b0;
    s_tdata_o  = '0;
    s_tkeep_o  = '0;
    s_tlast_o  = 1'b0;
    m_tready_o = '0;
    beat_done  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        s_tvalid_o          = m_tvalid_i[grant_q];
        s_tdata_o           = m_tdata_i[grant_q*AXI_WIDTH +: AXI_WIDTH];
        s_tkeep_o           = m_tkeep_i[grant_q*KEEP_W +: KEEP_W];
        s_tlast_o           = m_tlast_i[grant_q];
        m_tready_o[grant_q] = s_tready_i;
        beat_done           = s_tvalid_o & s_tready_i & s_tlast_o;
        if (beat_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and grant registers; last grant resets to the top port so port 0 wins first
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && pick_valid) begin
        grant_q <= pick_idx;
        last_q  <= pick_idx;
      end
    end
  end

  // Per-port completed-packet counters, bumped on the tlast handshake and free to wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (beat_done) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_q == IDX_W'(p)) begin
          cnt_q[p*PKT_CNT_W +: PKT_CNT_W] <= cnt_q[p*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
        end
      end
    end
  end

  assign busy_o      = (state_q == ARB_LOCKED);
  assign grant_idx_o = grant_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// tb/tb_axi4s_rr_arbiter.sv - directed self-checking bench for axi4s_rr_arbiter
module tb_axi4s_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic             clk;
  logic             rst_n;
  logic [NP*DW-1:0] m_tdata;
  logic [NP*KW-1:0] m_tkeep;
  logic [NP-1:0]    m_tlast;
  logic [NP-1:0]    m_tvalid;
  logic [NP-1:0]    m_tready;
  logic [DW-1:0]    s_tdata;
  logic [KW-1:0]    s_tkeep;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [NP*32-1:0] pkt_count;

  int n_assert = 0;
  int n_fail   = 0;

  axi4s_rr_arbiter #(
    .AXI_WIDTH(DW),
    .NUM_PORTS(NP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .m_tdata_i   (m_tdata),
    .m_tkeep_i   (m_tkeep),
    .m_tlast_i   (m_tlast),
    .m_tvalid_i  (m_tvalid),
    .m_tready_o  (m_tready),
    .s_tdata_o   (s_tdata),
    .s_tkeep_o   (s_tkeep),
    .s_tlast_o   (s_tlast),
    .s_tvalid_o  (s_tvalid),
    .s_tready_i  (s_tready),
    .grant_idx_o (grant_idx),
    .busy_o      (busy),
    .pkt_count_o (pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] beat_data(int p, int b);
    return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(b);
  endfunction

  function automatic logic [31:0] cnt(int p);
    return pkt_count[p*32 +: 32];
  endfunction

  task automatic chk(string tag, logic [63:0] observed, logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(int p, logic v, int b, logic l);
    m_tvalid[p]         = v;
    m_tdata[p*DW +: DW] = beat_data(p, b);
    m_tkeep[p*KW +: KW] = 8'(p * 16 + b);
    m_tlast[p]          = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_tvalid = '0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = '0;
    s_tready = 1'b1;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  int         beat[NP];
  int         sent[NP];
  int         pk;
  int         ob;
  int         b;
  logic       tr;
  logic [3:0] hs;
  logic       ohs;

  initial begin
    rst_n    = 1'b0;
    m_tvalid = '0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = '0;
    s_tready = 1'b1;
    tick();
    tick();

    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_svalid", 64'(s_tvalid), 64'd0);
    chk("rst_mready", 64'(m_tready), 64'd0);
    chk("rst_sdata", s_tdata, 64'd0);
    chk("rst_cnt_lo", pkt_count[63:0], 64'd0);
    chk("rst_cnt_hi", pkt_count[127:64], 64'd0);
    rst_n = 1'b1;
    #1;

    // ports 1 and 3 request; port 1 wins, port 3 follows after an idle cycle
    drive(1, 1'b1, 0, 1'b0);
    drive(3, 1'b1, 0, 1'b1);
    #1;
    chk("t1_idle_svalid", 64'(s_tvalid), 64'd0);
    tick();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant1", 64'(grant_idx), 64'd1);
    chk("t1_mready", 64'(m_tready), 64'b0010);
    chk("t1_data0", s_tdata, beat_data(1, 0));
    chk("t1_keep0", 64'(s_tkeep), 64'(8'h10));
    chk("t1_last0", 64'(s_tlast), 64'd0);
    tick();
    drive(1, 1'b1, 1, 1'b1);
    #1;
    chk("t1_data1", s_tdata, beat_data(1, 1));
    chk("t1_last1", 64'(s_tlast), 64'd1);
    tick();
    drive(1, 1'b0, 0, 1'b0);
    #1;
    chk("t1_gap_busy", 64'(busy), 64'd0);
    chk("t1_gap_svalid", 64'(s_tvalid), 64'd0);
    chk("t1_gap_mready", 64'(m_tready), 64'd0);
    chk("t1_cnt1", 64'(cnt(1)), 64'd1);
    chk("t1_gap_grant", 64'(grant_idx), 64'd1);
    tick();
    chk("t1_grant3", 64'(grant_idx), 64'd3);
    chk("t1_busy3", 64'(busy), 64'd1);
    chk("t1_data3", s_tdata, beat_data(3, 0));
    chk("t1_mready3", 64'(m_tready), 64'b1000);
    tick();
    drive(3, 1'b0, 0, 1'b0);
    #1;
    chk("t1_cnt3", 64'(cnt(3)), 64'd1);
    chk("t1_end_busy", 64'(busy), 64'd0);

    // all ports stream 3-beat packets: fair rotation, contiguous packets
    do_reset();
    for (int p = 0; p < NP; p++) begin
      beat[p] = 0;
      sent[p] = 0;
    end
    pk = 0;
    ob = 0;
    for (int cyc = 0; cyc < 64 && pk < 8; cyc++) begin
      for (int p = 0; p < NP; p++) drive(p, sent[p] < 2, beat[p], beat[p] == 2);
      #1;
      hs  = m_tvalid & m_tready;
      ohs = s_tvalid & s_tready;
      if (s_tvalid) begin
        chk("t2_port", 64'(grant_idx), 64'(pk % 4));
        chk("t2_data", s_tdata, beat_data(pk % 4, ob));
        chk("t2_last", 64'(s_tlast), 64'(ob == 2));
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        if (hs[p]) begin
          beat[p]++;
          if (beat[p] == 3) begin
            beat[p] = 0;
            sent[p]++;
          end
        end
      end
      if (ohs) begin
        if (ob == 2) begin
          ob = 0;
          pk++;
        end else begin
          ob++;
        end
      end
    end
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 0, 1'b0);
    chk("t2_pkts", 64'(pk), 64'd8);
    for (int p = 0; p < NP; p++) chk("t2_cnt", 64'(cnt(p)), 64'd2);

    // port 2 five-beat packet under toggling ready; port 0 held off
    do_reset();
    drive(2, 1'b1, 0, 1'b0);
    tick();
    chk("t3_grant2", 64'(grant_idx), 64'd2);
    drive(0, 1'b1, 0, 1'b1);
    b  = 0;
    tr = 1'b1;
    for (int cyc = 0; cyc < 30 && b < 5; cyc++) begin
      drive(2, 1'b1, b, b == 4);
      s_tready = tr;
      #1;
      chk("t3_rdy0", 64'(m_tready[0]), 64'd0);
      chk("t3_rdy2", 64'(m_tready[2]), 64'(tr));
      chk("t3_data", s_tdata, beat_data(2, b));
      tick();
      if (tr) b++;
      tr = ~tr;
    end
    chk("t3_beats", 64'(b), 64'd5);
    drive(2, 1'b0, 0, 1'b0);
    s_tready = 1'b1;
    #1;
    chk("t3_idle_busy", 64'(busy), 64'd0);
    chk("t3_idle_rdy0", 64'(m_tready[0]), 64'd0);
    tick();
    chk("t3_grant0", 64'(grant_idx), 64'd0);
    chk("t3_mready0", 64'(m_tready), 64'b0001);
    tick();
    drive(0, 1'b0, 0, 1'b0);
    #1;
    chk("t3_cnt0", 64'(cnt(0)), 64'd1);
    chk("t3_cnt2", 64'(cnt(2)), 64'd1);

    // back-to-back single-beat packets on port 0: one beat every other cycle
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, k, 1'b1);
      #1;
      chk("t4_svalid", 64'(s_tvalid), 64'(k % 2));
      chk("t4_grant", 64'(grant_idx), 64'd0);
      tick();
    end
    drive(0, 1'b0, 0, 1'b0);
    #1;
    chk("t4_cnt0", 64'(cnt(0)), 64'd5);

    // reset asserted on the second beat of a port 1 packet
    drive(1, 1'b1, 0, 1'b0);
    tick();
    chk("t5_grant1", 64'(grant_idx), 64'd1);
    tick();
    drive(1, 1'b1, 1, 1'b0);
    #1;
    chk("t5_pre_svalid", 64'(s_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_svalid", 64'(s_tvalid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant", 64'(grant_idx), 64'd0);
    chk("t5_mready", 64'(m_tready), 64'd0);
    chk("t5_cnt0", 64'(cnt(0)), 64'd0);
    chk("t5_cnt2", 64'(cnt(2)), 64'd0);
    drive(0, 1'b1, 0, 1'b1);
    drive(1, 1'b1, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_after_grant", 64'(grant_idx), 64'd0);
    chk("t5_after_busy", 64'(busy), 64'd1);
    chk("t5_after_data", s_tdata, beat_data(0, 0));

    // port 3 counter wraps from all-ones to zero
    do_reset();
    force dut.cnt_q = {32'hFFFF_FFFF, 96'h0};
    #1;
    release dut.cnt_q;
    #1;
    chk("t6_preload", 64'(cnt(3)), 64'hFFFF_FFFF);
    drive(3, 1'b1, 0, 1'b1);
    tick();
    chk("t6_grant3", 64'(grant_idx), 64'd3);
    tick();
    drive(3, 1'b0, 0, 1'b0);
    #1;
    chk("t6_wrap", 64'(cnt(3)), 64'd0);
    chk("t6_cnt0", 64'(cnt(0)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
